// File: rtl/seq_sub_chunked.sv
// Multi-cycle subtractor: C = A - B - BIN, CHUNK bits per clock, LSB chunk first,
// with the borrow carried between cycles and valid/ready handshakes on both sides.
module seq_sub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] C,
    output logic             BOUT,
    output logic             OVF,
    output logic             ZERO
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   diff;
    logic [WIDTH-1:0] acc_next;
    logic             last_chunk;

    // Operands shift right each RUN cycle, so the active chunk is always in the low bits.
    assign diff       = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    assign acc_next   = (acc_q >> CHUNK) | (WIDTH'(diff[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign last_chunk = (cnt_q == CW'(N - 1));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        c_d      = c_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = BIN;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                borrow_d = diff[CHUNK];
                cnt_d    = cnt_q + CW'(1);
                acc_d    = acc_next;
                if (last_chunk) begin
                    // Published results stay frozen until a whole new difference exists.
                    c_d     = acc_next;
                    bout_d  = diff[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] != b_q[CHUNK-1]) && (diff[CHUNK-1] != a_q[CHUNK-1]);
                    zero_d  = (acc_next == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            c_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            c_q      <= c_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // NOTE: operand and accumulator registers are not reset; they are always loaded before use.
    always_ff @(posedge CLK) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign C         = c_q;
    assign BOUT      = bout_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_seq_sub_chunked.sv
// Bench for seq_sub_chunked: four geometries run side by side on shared stimulus,
// checked against fixed vectors and an integer-arithmetic reference model.
module tb_seq_sub_chunked;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;

    logic [3:0]       in_ready_w, out_valid_w, bout_w, ovf_w, zero_w;
    logic [3:0][15:0] c_w;
    logic [7:0]       c3;

    assign c_w[3] = {8'h00, c3};

    int n_of[4] = '{4, 1, 16, 4};
    int w_of[4] = '{16, 16, 16, 8};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_sub_chunked #(.WIDTH(16), .CHUNK(4)) dut0 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_w[0]),
        .A(a), .B(b), .BIN(bin), .OUT_VALID(out_valid_w[0]), .OUT_READY(out_ready),
        .C(c_w[0]), .BOUT(bout_w[0]), .OVF(ovf_w[0]), .ZERO(zero_w[0]));
    seq_sub_chunked #(.WIDTH(16), .CHUNK(16)) dut1 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_w[1]),
        .A(a), .B(b), .BIN(bin), .OUT_VALID(out_valid_w[1]), .OUT_READY(out_ready),
        .C(c_w[1]), .BOUT(bout_w[1]), .OVF(ovf_w[1]), .ZERO(zero_w[1]));
    seq_sub_chunked #(.WIDTH(16), .CHUNK(1)) dut2 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_w[2]),
        .A(a), .B(b), .BIN(bin), .OUT_VALID(out_valid_w[2]), .OUT_READY(out_ready),
        .C(c_w[2]), .BOUT(bout_w[2]), .OVF(ovf_w[2]), .ZERO(zero_w[2]));
    seq_sub_chunked #(.WIDTH(8), .CHUNK(2)) dut3 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_w[3]),
        .A(a[7:0]), .B(b[7:0]), .BIN(bin), .OUT_VALID(out_valid_w[3]), .OUT_READY(out_ready),
        .C(c3), .BOUT(bout_w[3]), .OVF(ovf_w[3]), .ZERO(zero_w[3]));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] c;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[7];

    int          got_lat[4];
    logic [15:0] got_c[4];
    logic        got_b[4], got_o[4], got_z[4], got_rdy[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w, signed overflow from range limits.
    function automatic void model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mbin, output logic [15:0] c, output logic bout,
                                  output logic ovf, output logic zero);
        int mask = (1 << w) - 1;
        int half = 1 << (w - 1);
        int av   = int'(ma) & mask;
        int bv   = int'(mb) & mask;
        int d    = av - bv - int'(mbin);
        int sa   = (av >= half) ? av - (1 << w) : av;
        int sb   = (bv >= half) ? bv - (1 << w) : bv;
        int sd   = sa - sb - int'(mbin);
        c    = 16'(d & mask);
        bout = (d < 0);
        ovf  = (sd < -half) || (sd > half - 1);
        zero = ((d & mask) == 0);
    endfunction

    task automatic wait_all_ready();
        int guard = 0;
        @(negedge clk);
        while (in_ready_w != 4'hF && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", {28'h0, in_ready_w}, 32'hF);
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        wait_all_ready();
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got_lat[i] = -1;
            got_rdy[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (got_lat[i] < 0 && out_valid_w[i]) begin
                    got_lat[i] = cyc;
                    got_c[i] = c_w[i]; got_b[i] = bout_w[i];
                    got_o[i] = ovf_w[i]; got_z[i] = zero_w[i];
                end else if (got_lat[i] >= 0 && cyc == got_lat[i] + 1) begin
                    got_rdy[i] = in_ready_w[i] & ~out_valid_w[i];
                end
            end
        end
    endtask

    task automatic check_results(input vec_t v, input logic use_tab);
        logic [15:0] ec;
        logic eb, eo, ez;
        for (int i = 0; i < 4; i++) begin
            if (use_tab && w_of[i] == 16) begin
                ec = v.c; eb = v.bout; eo = v.ovf; ez = v.zero;
            end else begin
                model(w_of[i], v.a, v.b, v.bin, ec, eb, eo, ez);
            end
            check($sformatf("lat[%0d] a=%h b=%h", i, v.a, v.b), 32'(got_lat[i]), 32'(n_of[i]));
            check($sformatf("c[%0d] a=%h b=%h bin=%b", i, v.a, v.b, v.bin), {16'h0, got_c[i]}, {16'h0, ec});
            check($sformatf("bout[%0d] a=%h b=%h", i, v.a, v.b), {31'h0, got_b[i]}, {31'h0, eb});
            check($sformatf("ovf[%0d] a=%h b=%h", i, v.a, v.b), {31'h0, got_o[i]}, {31'h0, eo});
            check($sformatf("zero[%0d] a=%h b=%h", i, v.a, v.b), {31'h0, got_z[i]}, {31'h0, ez});
            check($sformatf("ready_after[%0d]", i), {31'h0, got_rdy[i]}, 32'h1);
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s in_ready[%0d]", tag, i), {31'h0, in_ready_w[i]}, 32'h1);
            check($sformatf("%s out_valid[%0d]", tag, i), {31'h0, out_valid_w[i]}, 32'h0);
            check($sformatf("%s outs[%0d]", tag, i),
                  {13'h0, bout_w[i], ovf_w[i], zero_w[i], c_w[i]}, 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        rv;
        logic [3:0]  hold_ok;
        logic [3:0]  emitted;

        vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");

        for (int k = 0; k < 6; k++) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].bin);
            check_results(vecs[k], 1'b1);
        end

        // Result held under back-pressure; an IN_VALID pulse in DONE must be ignored.
        wait_all_ready();
        a = 16'h5A5A; b = 16'h5A5A; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) @(negedge clk);
        hold_ok = 4'hF;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t == 3);
            a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!(out_valid_w[i] && !in_ready_w[i] && c_w[i] == 16'h0 && zero_w[i] &&
                      !bout_w[i] && !ovf_w[i]))
                    hold_ok[i] = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            check($sformatf("hold_stable[%0d]", i), {31'h0, hold_ok[i]}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready", {28'h0, in_ready_w}, 32'hF);
        check("release_valid", {28'h0, out_valid_w}, 32'h0);

        // Reset two chunks into an operation that leaves a borrow pending.
        wait_all_ready();
        a = 16'h0000; b = 16'hFFFF; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("abort");
        emitted = 4'h0;
        repeat (20) begin
            @(negedge clk);
            emitted = emitted | out_valid_w;
        end
        check("abort_no_emit", {28'h0, emitted}, 32'h0);
        run_op(vecs[6].a, vecs[6].b, vecs[6].bin);
        check_results(vecs[6], 1'b1);

        for (int k = 0; k < 40; k++) begin
            rv.a   = (k % 8 == 0) ? 16'hFFFF : 16'($urandom);
            rv.b   = (k % 8 == 1) ? 16'hFFFF : (k % 8 == 2) ? rv.a : 16'($urandom);
            rv.bin = 1'($urandom);
            rv.c = '0; rv.bout = 1'b0; rv.ovf = 1'b0; rv.zero = 1'b0;
            run_op(rv.a, rv.b, rv.bin);
            check_results(rv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
